// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the 1-bit frame-buffer pixel fetch path.
package fb_pkg;
  localparam int FB_X_MAX = 160;
  localparam int FB_Y_MAX = 80;

  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_OOR  = 2'd3
  } fetch_state_t;

  function automatic logic [15:0] bit_to_rgb(input logic b, input logic [15:0] fg,
                                             input logic [15:0] bg);
    return b ? fg : bg;
  endfunction
endpackage

// File: rtl/fb_pixel_fetch_if.sv
// Bundles the pixel-request, writer and BRAM-side signals of fb_pixel_fetch.
interface fb_pixel_fetch_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        px_x;
  logic [6:0]        px_y;
  logic              next_pixel;
  logic [15:0]       color;
  logic              color_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;
  logic              mem_dout;
  logic              mem_we;
  logic              busy;
  logic              ovf;

  modport slave (
    input  px_x, px_y, next_pixel, wr_req, wr_addr, wr_data, mem_dout,
    output color, color_done, wr_ack, mem_addr, mem_din, mem_we, busy, ovf
  );

  modport master (
    output px_x, px_y, next_pixel, wr_req, wr_addr, wr_data, mem_dout,
    input  color, color_done, wr_ack, mem_addr, mem_din, mem_we, busy, ovf
  );
endinterface

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its frame-buffer bit address and flags off-screen requests.
module fb_addr_calc #(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 80,
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);
  logic [14:0] lin;

  // Range check uses the full-width coordinates so a truncated address can never alias.
  assign in_range = (32'(x) < 32'(X_MAX)) && (32'(y) < 32'(Y_MAX));
  assign lin      = 15'(32'(y) * 32'(X_MAX) + 32'(x));
  assign addr     = ADDR_W'(32'(BASE_ADDR) + 32'(lin));
endmodule

// File: rtl/fb_pixel_fetch.sv
// Serves st7735 pixel requests from a 1-bit frame buffer and arbitrates one writer into the same BRAM.
module fb_pixel_fetch
  import fb_pkg::*;
#(
  parameter int          X_MAX     = FB_X_MAX,
  parameter int          Y_MAX     = FB_Y_MAX,
  parameter int          ADDR_W    = 14,
  parameter int          BASE_ADDR = 0,
  parameter int          RD_LAT    = 1,
  parameter logic [15:0] FG_COLOR  = RGB565_WHITE,
  parameter logic [15:0] BG_COLOR  = RGB565_BLACK,
  parameter logic [15:0] OOR_COLOR = RGB565_BLACK
) (
  input  logic             clk,
  input  logic             rst,
  fb_pixel_fetch_if.slave  bus
);
  fetch_state_t      state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic              prev_np_reg;
  logic              pend_reg, pend_next;
  logic              ovf_reg, ovf_next;
  logic              done_reg, done_next;
  logic [15:0]       color_reg, color_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic              edge_det;
  logic              in_range;
  logic [ADDR_W-1:0] calc_addr;
  logic              mem_we;

  fb_addr_calc #(
    .X_MAX    (X_MAX),
    .Y_MAX    (Y_MAX),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_calc (
    .x       (bus.px_x),
    .y       (bus.px_y),
    .in_range(in_range),
    .addr    (calc_addr)
  );

  assign edge_det = bus.next_pixel & ~prev_np_reg;
  assign mem_we   = bus.wr_req & (state_reg == ST_IDLE) & ~edge_det & ~pend_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    color_next = color_reg;
    addr_next  = addr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (edge_det || pend_reg) begin
          // Serving the pending slot while a fresh edge arrives keeps that edge queued.
          pend_next = edge_det & pend_reg;
          cnt_next  = 2'd0;
          if (in_range) begin
            addr_next  = calc_addr;
            state_next = ST_READ;
          end else begin
            state_next = ST_OOR;
          end
        end
      end
      ST_READ: begin
        if (cnt_reg == 2'(RD_LAT - 1)) begin
          cnt_next   = 2'd0;
          state_next = ST_CAPT;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      ST_CAPT: begin
        color_next = bit_to_rgb(bus.mem_dout, FG_COLOR, BG_COLOR);
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_OOR: begin
        color_next = OOR_COLOR;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if ((state_reg != ST_IDLE) && edge_det) begin
      if (pend_reg) ovf_next = 1'b1;
      else          pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 2'd0;
      prev_np_reg <= 1'b0;
      pend_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
      color_reg   <= BG_COLOR;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      prev_np_reg <= bus.next_pixel;
      pend_reg    <= pend_next;
      ovf_reg     <= ovf_next;
      done_reg    <= done_next;
      color_reg   <= color_next;
      addr_reg    <= addr_next;
    end
  end

  assign bus.mem_we     = mem_we;
  assign bus.wr_ack     = mem_we;
  assign bus.mem_addr   = mem_we ? bus.wr_addr : addr_reg;
  assign bus.mem_din    = mem_we & bus.wr_data;
  assign bus.color      = color_reg;
  assign bus.color_done = done_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.ovf        = ovf_reg;
endmodule
